// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared constants for the instruction loader: FSM state
//                encoding, default word geometry and end-of-program marker.
//                Also used by the debug unit to decode loader state.
//  Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    // Loader FSM state encoding
    localparam int         C_STATE_W   = 3;
    localparam logic [2:0] C_ST_IDLE   = 3'd0;
    localparam logic [2:0] C_ST_RECV   = 3'd1;
    localparam logic [2:0] C_ST_WRITE  = 3'd2;
    localparam logic [2:0] C_ST_DONE   = 3'd3;
    localparam logic [2:0] C_ST_ERROR  = 3'd4;

    // Default word geometry
    localparam int          C_DEFAULT_INST_SZ  = 32;
    localparam int          C_DEFAULT_BYTE_SZ  = 8;
    localparam int          C_BYTES_PER_INST   = C_DEFAULT_INST_SZ / C_DEFAULT_BYTE_SZ;
    localparam logic [31:0] C_DEFAULT_HALT_INST = 32'hFFFF_FFFF;

    // Number of received bytes that make up one instruction word
    function automatic int bytes_per_word(input int inst_sz, input int byte_sz);
        return inst_sz / byte_sz;
    endfunction

endpackage : loader_pkg
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : word_assembler
//  Description : Big-endian byte-to-word assembler. Shifts accepted bytes in
//                MSB first and flags (combinationally) the byte that
//                completes a word, presenting the complete word alongside.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_assembler
    import loader_pkg::*;
#(
    parameter int INST_SZ = 32,
    parameter int BYTE_SZ = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,       // asynchronous, active-low
    input  logic               i_clear,       // drop any partial word
    input  logic               i_accept,      // capture i_byte this cycle
    input  logic [BYTE_SZ-1:0] i_byte,
    output logic [INST_SZ-1:0] o_word,        // word including i_byte
    output logic               o_word_ready   // i_byte completes a word
);

    localparam int                 C_BYTES = bytes_per_word(INST_SZ, BYTE_SZ);
    localparam int                 C_CNT_W = (C_BYTES > 1) ? $clog2(C_BYTES) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(C_BYTES - 1);

    logic [C_CNT_W-1:0] r_cnt_q;
    logic [C_CNT_W-1:0] w_cnt_d;
    logic [INST_SZ-1:0] r_shift_q;
    logic [INST_SZ-1:0] w_shift_d;
    logic [INST_SZ-1:0] w_next_word;

    // Earlier bytes move toward the MSB, so the first byte ends up on top
    assign w_next_word  = (r_shift_q << BYTE_SZ) | INST_SZ'(i_byte);
    assign o_word       = w_next_word;
    assign o_word_ready = i_accept && !i_clear && (r_cnt_q == C_LAST);

    // Byte counter and shift register next-state
    always_comb begin
        w_cnt_d   = r_cnt_q;
        w_shift_d = r_shift_q;
        if (i_clear) begin
            w_cnt_d   = '0;
            w_shift_d = '0;
        end else if (i_accept) begin
            w_shift_d = w_next_word;
            w_cnt_d   = (r_cnt_q == C_LAST) ? '0 : r_cnt_q + 1'b1;
        end
    end

    // Assembler state registers
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt_q   <= '0;
            r_shift_q <= '0;
        end else begin
            r_cnt_q   <= w_cnt_d;
            r_shift_q <= w_shift_d;
        end
    end

endmodule : word_assembler
`default_nettype wire

// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
//  Module      : inst_loader
//  Description : Loads a program into instruction memory from a received byte
//                stream. Assembles big-endian words and issues one-cycle
//                writes with incrementing byte addresses until the halt word
//                is written or the memory is full. Holds the pipeline via
//                o_busy while loading.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_loader
    import loader_pkg::*;
#(
    parameter int                 INST_SZ   = 32,
    parameter int                 BYTE_SZ   = 8,
    parameter int                 PC_SZ     = 32,
    parameter int                 MEM_DEPTH = 256,
    parameter logic [INST_SZ-1:0] HALT_INST = INST_SZ'(C_DEFAULT_HALT_INST)
) (
    input  logic               i_clk,
    input  logic               i_reset,        // asynchronous, active-low
    input  logic               i_start,
    input  logic [BYTE_SZ-1:0] i_rx_data,
    input  logic               i_rx_done,
    output logic               o_write,
    output logic [PC_SZ-1:0]   o_write_addr,
    output logic [INST_SZ-1:0] o_instruction,
    output logic               o_busy,
    output logic               o_load_done,
    output logic               o_overflow,
    output logic [PC_SZ-1:0]   o_inst_count
);

    localparam logic [PC_SZ-1:0] C_ADDR_STEP = PC_SZ'(INST_SZ / 8);
    localparam logic [PC_SZ-1:0] C_DEPTH     = PC_SZ'(MEM_DEPTH);

    logic [C_STATE_W-1:0] r_state_q;
    logic [C_STATE_W-1:0] w_state_d;
    logic [PC_SZ-1:0]     r_addr_q;
    logic [PC_SZ-1:0]     w_addr_d;
    logic [PC_SZ-1:0]     r_count_q;
    logic [PC_SZ-1:0]     w_count_d;
    logic [PC_SZ-1:0]     w_count_inc;

    logic                 r_write_q;
    logic                 w_write_d;
    logic [PC_SZ-1:0]     r_write_addr_q;
    logic [PC_SZ-1:0]     w_write_addr_d;
    logic [INST_SZ-1:0]   r_instruction_q;
    logic [INST_SZ-1:0]   w_instruction_d;
    logic                 r_busy_q;
    logic                 w_busy_d;
    logic                 r_load_done_q;
    logic                 w_load_done_d;
    logic                 r_overflow_q;
    logic                 w_overflow_d;

    logic                 w_restart;
    logic                 w_accept;
    logic [INST_SZ-1:0]   w_word;
    logic                 w_word_ready;

    // A load may only (re)start when no load is in flight
    assign w_restart   = i_start && ((r_state_q == C_ST_IDLE) ||
                                     (r_state_q == C_ST_DONE) ||
                                     (r_state_q == C_ST_ERROR));
    assign w_count_inc = r_count_q + 1'b1;

    // A byte arriving during WRITE starts the next word, unless the load ends
    assign w_accept = i_rx_done && ((r_state_q == C_ST_RECV) ||
                                    ((r_state_q == C_ST_WRITE) && (w_state_d == C_ST_RECV)));

    word_assembler #(
        .INST_SZ (INST_SZ),
        .BYTE_SZ (BYTE_SZ)
    ) u_word_assembler (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (w_restart),
        .i_accept     (w_accept),
        .i_byte       (i_rx_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    // FSM state register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state_q <= C_ST_IDLE;
        else          r_state_q <= w_state_d;
    end

    // FSM next-state: the written word (held in r_instruction_q) picks the exit of WRITE
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            C_ST_IDLE, C_ST_DONE, C_ST_ERROR: if (i_start) w_state_d = C_ST_RECV;
            C_ST_RECV:  if (w_word_ready) w_state_d = C_ST_WRITE;
            C_ST_WRITE: begin
                if (r_instruction_q == HALT_INST) w_state_d = C_ST_DONE;
                else if (w_count_inc == C_DEPTH)  w_state_d = C_ST_ERROR;
                else                              w_state_d = C_ST_RECV;
            end
            default:    w_state_d = C_ST_IDLE;
        endcase
    end

    // FSM outputs and address/count bookkeeping, registered from the next state
    always_comb begin
        w_addr_d        = r_addr_q;
        w_count_d       = r_count_q;
        if (w_restart) begin
            w_addr_d  = '0;
            w_count_d = '0;
        end else if (r_state_q == C_ST_WRITE) begin
            w_addr_d  = r_addr_q + C_ADDR_STEP;
            w_count_d = w_count_inc;
        end
        w_write_d       = (w_state_d == C_ST_WRITE);
        w_write_addr_d  = w_write_d ? r_addr_q : r_write_addr_q;
        w_instruction_d = w_write_d ? w_word   : r_instruction_q;
        w_busy_d        = (w_state_d == C_ST_RECV) || (w_state_d == C_ST_WRITE);
        w_load_done_d   = (w_state_d == C_ST_DONE);
        w_overflow_d    = (w_state_d == C_ST_ERROR);
    end

    // Datapath and output registers
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_addr_q        <= '0;
            r_count_q       <= '0;
            r_write_q       <= 1'b0;
            r_write_addr_q  <= '0;
            r_instruction_q <= '0;
            r_busy_q        <= 1'b0;
            r_load_done_q   <= 1'b0;
            r_overflow_q    <= 1'b0;
        end else begin
            r_addr_q        <= w_addr_d;
            r_count_q       <= w_count_d;
            r_write_q       <= w_write_d;
            r_write_addr_q  <= w_write_addr_d;
            r_instruction_q <= w_instruction_d;
            r_busy_q        <= w_busy_d;
            r_load_done_q   <= w_load_done_d;
            r_overflow_q    <= w_overflow_d;
        end
    end

    assign o_write       = r_write_q;
    assign o_write_addr  = r_write_addr_q;
    assign o_instruction = r_instruction_q;
    assign o_busy        = r_busy_q;
    assign o_load_done   = r_load_done_q;
    assign o_overflow    = r_overflow_q;
    assign o_inst_count  = r_count_q;

endmodule : inst_loader
`default_nettype wire
